falu_cmp_pipe: RTL and testbench
================================

FALU_CMP_PIPE -- requirements
Module: falu_cmp_pipe

Interface
REQ-001 SHALL have parameter LATENCY, default 2: number of register stages from input acceptance to output valid (legal 1..4).
REQ-002 SHALL have parameter TAG_W, default 6: width of the opaque tag carried with each operation.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous active-high reset.
REQ-005 SHALL have port flush, input, 1: synchronous kill of all in-flight operations.
REQ-006 SHALL have ports in_valid (input, 1) and in_ready (output, 1): the input handshake.
REQ-007 SHALL have ports in_op (input, 3), in_dbl (input, 1), in_a (input, 64), in_b (input, 64) and in_tag (input, TAG_W): the op code per FPU_SUBOP_CMP_{EQ,LT,LE,MIN,MAX,CLASS}, 1 = double, the two operands, and the tag.
REQ-008 SHALL have ports out_valid (output, 1) and out_ready (input, 1): the output handshake.
REQ-009 SHALL have ports out_data (output, 64), out_fflags (output, 5, {NV,DZ,OF,UF,NX}) and out_tag (output, TAG_W).

Function
REQ-010 SHALL accept an operation when in_valid & in_ready & ~flush.
REQ-011 SHALL drive in_ready = ~out_valid | out_ready, so the whole pipe advances together and holds on stall.
REQ-012 SHALL, on advance with no accept, insert a bubble; bubbles SHALL NOT be collapsed.
REQ-013 SHALL, for an accepted op that never stalls, assert out_valid exactly LATENCY cycles after the accept edge.
REQ-014 SHALL, while out_valid & ~out_ready, hold out_data, out_fflags and out_tag stable.
REQ-015 SHALL, when in_dbl=0 and an operand's bits [63:32] are not all ones, treat that operand as canonical qNaN 0x7FC00000.
REQ-016 SHALL classify each operand: sNaN, qNaN, +/-inf, +/-normal, +/-subnormal, +/-zero.
REQ-017 SHALL compute EQ as 1 when operands are numerically equal (+0 == -0 counts as equal).
REQ-018 SHALL compute EQ as 0 if either operand is NaN, with NV set only when either is sNaN.
REQ-019 SHALL compute LT and LE with IEEE ordering (LT(-0,+0)=0, LE(-0,+0)=1).
REQ-020 SHALL compute LT and LE as 0 with NV set if either operand is NaN.
REQ-021 SHALL treat -0 < +0 for MIN and MAX.
REQ-022 SHALL, for MIN and MAX, return the other operand when exactly one is NaN.
REQ-023 SHALL, for MIN and MAX, return the canonical qNaN (DP 0x7FF8000000000000, SP 0x7FC00000) when both are NaN.
REQ-024 SHALL, for MIN and MAX, set NV whenever either operand is sNaN.
REQ-025 SHALL return a zero-extended one-hot 10-bit RISC-V class mask of in_a for CLASS; in_b is ignored and no flags are set.
REQ-026 SHALL return 0 or 1 zero-extended to 64 bits for compare ops (EQ/LT/LE).
REQ-027 SHALL return SP MIN/MAX results NaN-boxed ({32'hFFFFFFFF, result}).
REQ-028 SHALL return out_data=0 and flags=0 for undefined in_op.
REQ-029 SHALL keep out_fflags[3:0] always 0.
REQ-030 SHALL place classification in stage 1 and result select in the final stage; intermediate stages (LATENCY>2) SHALL be pure pass-through registers.
REQ-031 SHALL, when LATENCY=1, compute classification and result in one combinational stage.
REQ-032 SHALL, on flush, clear every stage valid bit, including out_valid, at that edge.
REQ-033 SHALL, on flush, discard any input presented in that cycle.
REQ-034 SHALL treat flush and out_ready in the same cycle as flush (output dropped).
REQ-035 SHALL let data and tag registers of invalid stages hold any value, except as REQ-037 requires.

Reset
REQ-036 SHALL, on reset, clear all stage valid bits (out_valid=0, so in_ready=1).
REQ-037 SHALL, on reset, drive out_data=0, out_fflags=0 and out_tag=0.
REQ-038 SHALL let reset take priority over flush and over an in-flight accept; operations in flight at reset are lost.

Verification
REQ-039 SHALL cover DP EQ: a=+0.0 (0x0), b=-0.0 (0x8000000000000000) -> out_data=1, fflags=0, after LATENCY cycles.
REQ-040 SHALL cover SP LT with qNaN: a=0xFFFFFFFF7FC00000, b=0xFFFFFFFF3F800000 -> out_data=0, fflags=5'b10000.
REQ-041 SHALL cover DP MAX with sNaN: a=0x7FF0000000000001, b=0x3FF0000000000000 -> out_data=0x3FF0000000000000, NV=1.
REQ-042 SHALL cover SP MIN with an unboxed operand: a=0x000000003F800000, b=0xFFFFFFFFBF800000 -> out_data=0xFFFFFFFFBF800000, fflags=0.
REQ-043 SHALL cover backpressure: 3 back-to-back ops with out_ready=0 for 5 cycles -> in_ready=0 once out_valid=1, no loss or reorder, tags emerge in order after out_ready=1.
REQ-044 SHALL cover flush mid-flight: 2 ops in flight, flush for 1 cycle -> neither appears; an op accepted the next cycle emerges after LATENCY cycles.

Source files
------------

// File: rtl/falu_cmp_pipe.sv
// Pipelined FP compare/min/max/classify unit for single and double precision.
// Stage 1 classifies the operands, the last stage selects the result; stages in between only delay.
module falu_cmp_pipe #(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned TAG_W   = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_dbl,
  input  logic [63:0]      in_a,
  input  logic [63:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [4:0]       out_fflags,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [2:0] {
    OP_EQ    = 3'd0,
    OP_LT    = 3'd1,
    OP_LE    = 3'd2,
    OP_MIN   = 3'd3,
    OP_MAX   = 3'd4,
    OP_CLASS = 3'd5
  } op_e;

  typedef struct packed {
    logic [2:0]       op;
    logic             dbl;
    logic [63:0]      a;
    logic [63:0]      b;
    logic [9:0]       ca;
    logic [2:0]       kb;   // {nan, snan, zero} of operand b
    logic [TAG_W-1:0] tag;
  } stage_t;

  localparam int unsigned NS = (LATENCY > 1) ? LATENCY - 1 : 1;

  // SP operands that are not NaN-boxed become the boxed canonical qNaN
  function automatic logic [63:0] unbox(input logic [63:0] x, input logic dbl);
    if (dbl || (&x[63:32])) return x;
    return 64'hFFFF_FFFF_7FC0_0000;
  endfunction

  function automatic logic [9:0] fclass(input logic [63:0] x, input logic dbl);
    logic       s, eo, ez, fz, q;
    logic [9:0] m;
    if (dbl) begin
      s  = x[63];
      eo = &x[62:52];
      ez = ~|x[62:52];
      fz = ~|x[51:0];
      q  = x[51];
    end else begin
      s  = x[31];
      eo = &x[30:23];
      ez = ~|x[30:23];
      fz = ~|x[22:0];
      q  = x[22];
    end
    m = '0;
    if (eo && fz)       m[s ? 0 : 7] = 1'b1;
    else if (eo)        m[q ? 9 : 8] = 1'b1;
    else if (ez && fz)  m[s ? 3 : 4] = 1'b1;
    else if (ez)        m[s ? 2 : 5] = 1'b1;
    else                m[s ? 1 : 6] = 1'b1;
    return m;
  endfunction

  function automatic logic [2:0] fkind(input logic [63:0] x, input logic dbl);
    logic [9:0] m;
    m = fclass(x, dbl);
    return {|m[9:8], m[8], |m[4:3]};
  endfunction

  stage_t             cls_in;
  stage_t             stg [NS];
  stage_t             fin;
  logic [LATENCY-1:0] vld;
  logic               advance;
  logic               accept;

  assign out_valid = vld[LATENCY-1];
  assign in_ready  = ~out_valid | out_ready;
  assign advance   = in_ready;
  assign accept    = in_valid & in_ready & ~flush;

  always_comb begin
    cls_in     = '0;
    cls_in.op  = in_op;
    cls_in.dbl = in_dbl;
    cls_in.a   = unbox(in_a, in_dbl);
    cls_in.b   = unbox(in_b, in_dbl);
    cls_in.ca  = fclass(cls_in.a, in_dbl);
    cls_in.kb  = fkind(cls_in.b, in_dbl);
    cls_in.tag = in_tag;
  end

  always_ff @(posedge clk) begin
    if (advance && !flush) begin
      stg[0] <= cls_in;
      for (int unsigned i = 1; i < NS; i++) stg[i] <= stg[i-1];
    end
  end

  always_comb fin = (LATENCY == 1) ? cls_in : stg[NS-1];

  logic        sa, sb, nan_a, snan_a, zero_a, nan_b, snan_b, zero_b;
  logic        both_zero, eq, ord_lt, lt;
  logic [62:0] ma, mb;
  logic [63:0] canon, lo, hi;
  logic [63:0] res_data;
  logic        res_nv;

  always_comb begin
    sa        = fin.dbl ? fin.a[63] : fin.a[31];
    sb        = fin.dbl ? fin.b[63] : fin.b[31];
    ma        = fin.dbl ? fin.a[62:0] : {32'b0, fin.a[30:0]};
    mb        = fin.dbl ? fin.b[62:0] : {32'b0, fin.b[30:0]};
    nan_a     = |fin.ca[9:8];
    snan_a    = fin.ca[8];
    zero_a    = |fin.ca[4:3];
    {nan_b, snan_b, zero_b} = fin.kb;
    both_zero = zero_a & zero_b;
    eq        = ((sa == sb) && (ma == mb)) || both_zero;
    // total order with -0 < +0; the IEEE compares mask out the zero pair
    ord_lt    = (sa != sb) ? sa : (sa ? (ma > mb) : (ma < mb));
    lt        = ord_lt & ~both_zero;
    canon     = fin.dbl ? 64'h7FF8_0000_0000_0000 : 64'hFFFF_FFFF_7FC0_0000;
    lo        = ord_lt ? fin.a : fin.b;
    hi        = ord_lt ? fin.b : fin.a;
    res_data  = '0;
    res_nv    = 1'b0;
    case (fin.op)
      OP_EQ: begin
        res_data = {63'b0, ~(nan_a | nan_b) & eq};
        res_nv   = snan_a | snan_b;
      end
      OP_LT: begin
        res_data = {63'b0, ~(nan_a | nan_b) & lt};
        res_nv   = nan_a | nan_b;
      end
      OP_LE: begin
        res_data = {63'b0, ~(nan_a | nan_b) & (lt | eq)};
        res_nv   = nan_a | nan_b;
      end
      OP_MIN, OP_MAX: begin
        if (nan_a && nan_b) res_data = canon;
        else if (nan_a)     res_data = fin.b;
        else if (nan_b)     res_data = fin.a;
        else                res_data = (fin.op == OP_MIN) ? lo : hi;
        res_nv = snan_a | snan_b;
      end
      OP_CLASS: res_data = {54'b0, fin.ca};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld        <= '0;
      out_data   <= '0;
      out_fflags <= '0;
      out_tag    <= '0;
    end else if (flush) begin
      vld <= '0;
    end else if (advance) begin
      vld[0] <= accept;
      for (int unsigned i = 1; i < LATENCY; i++) vld[i] <= vld[i-1];
      out_data   <= res_data;
      out_fflags <= {res_nv, 4'b0};
      out_tag    <= fin.tag;
    end
  end

endmodule

// File: tb/tb_falu_cmp_pipe.sv
// Randomized and directed bench for falu_cmp_pipe against a real-valued reference model.
module tb_falu_cmp_pipe;

  localparam int unsigned LAT   = 2;
  localparam int unsigned TAG_W = 6;

  logic             clk = 1'b0;
  logic             reset, flush, in_valid, in_ready, in_dbl, out_valid, out_ready;
  logic [2:0]       in_op;
  logic [63:0]      in_a, in_b, out_data;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic [4:0]       out_fflags;

  falu_cmp_pipe #(.LATENCY(LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_dbl(in_dbl), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_fflags(out_fflags), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]      d;
    logic [4:0]       f;
    logic [TAG_W-1:0] t;
    int               cnt;
  } exp_t;

  exp_t             q[$];
  logic [TAG_W-1:0] fire_tags[$];
  int               n_vec = 0;
  int               n_mis = 0;
  int               cyc = 0;
  int               acc_cyc, fire_cyc;
  bit               fired, accepted;
  logic [63:0]      fire_d;
  logic [4:0]       fire_f;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit sgn(input logic [63:0] x, input logic dbl);
    return dbl ? x[63] : x[31];
  endfunction

  function automatic bit is_nan(input logic [63:0] x, input logic dbl);
    if (dbl) return (x[62:52] == 11'h7FF) && (x[51:0] != 0);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction

  function automatic bit is_snan(input logic [63:0] x, input logic dbl);
    return is_nan(x, dbl) && !(dbl ? x[51] : x[22]);
  endfunction

  function automatic real to_real(input logic [63:0] x, input logic dbl);
    logic [63:0] d;
    logic [7:0]  e;
    if (dbl) return $bitstoreal(x);
    e = x[30:23];
    if (e == 8'hFF) d = {x[31], 11'h7FF, 52'h0};
    else if (e == 8'h00)
      return (x[31] ? -1.0 : 1.0) * real'(x[22:0]) * $bitstoreal(64'h36A0_0000_0000_0000);
    else d = {x[31], 11'(e) + 11'd896, x[22:0], 29'h0};
    return $bitstoreal(d);
  endfunction

  function automatic int fcls(input logic [63:0] x, input logic dbl);
    real v, av;
    bit  n;
    n = sgn(x, dbl);
    if (is_nan(x, dbl)) return is_snan(x, dbl) ? 8 : 9;
    v  = to_real(x, dbl);
    av = (v < 0.0) ? -v : v;
    if (av > $bitstoreal(64'h7FEF_FFFF_FFFF_FFFF)) return n ? 0 : 7;
    if (v == 0.0) return n ? 3 : 4;
    if (av < (dbl ? $bitstoreal(64'h0010_0000_0000_0000) : $bitstoreal(64'h3810_0000_0000_0000)))
      return n ? 2 : 5;
    return n ? 1 : 6;
  endfunction

  function automatic logic [68:0] ref_op(input logic [2:0] op, input logic dbl,
                                         input logic [63:0] a, input logic [63:0] b);
    logic [63:0] ua, ub, d;
    bit          na, nb, xa, xb, nv, a_less;
    real         ra, rb;
    ua = (dbl || a[63:32] == 32'hFFFF_FFFF) ? a : 64'hFFFF_FFFF_7FC0_0000;
    ub = (dbl || b[63:32] == 32'hFFFF_FFFF) ? b : 64'hFFFF_FFFF_7FC0_0000;
    na = is_nan(ua, dbl);  nb = is_nan(ub, dbl);
    xa = is_snan(ua, dbl); xb = is_snan(ub, dbl);
    ra = na ? 0.0 : to_real(ua, dbl);
    rb = nb ? 0.0 : to_real(ub, dbl);
    d  = 64'h0;
    nv = 1'b0;
    case (op)
      3'd0: begin d = {63'b0, !(na || nb) && (ra == rb)}; nv = xa || xb; end
      3'd1: begin d = {63'b0, !(na || nb) && (ra <  rb)}; nv = na || nb; end
      3'd2: begin d = {63'b0, !(na || nb) && (ra <= rb)}; nv = na || nb; end
      3'd3, 3'd4: begin
        nv     = xa || xb;
        a_less = (ra < rb) || ((ra == rb) && sgn(ua, dbl) && !sgn(ub, dbl));
        if (na && nb) d = dbl ? 64'h7FF8_0000_0000_0000 : 64'hFFFF_FFFF_7FC0_0000;
        else if (na)  d = ub;
        else if (nb)  d = ua;
        else if (op == 3'd3) d = a_less ? ua : ub;
        else                 d = a_less ? ub : ua;
      end
      3'd5: d = 64'd1 << fcls(ua, dbl);
      default: ;
    endcase
    return {nv, 4'b0, d};
  endfunction

  // ---------------- per-cycle scoreboard ----------------
  task automatic eval();
    bit          vis;
    logic [68:0] r;
    vis      = (q.size() > 0) && (q[0].cnt == int'(LAT));
    fired    = 0;
    accepted = 0;
    chk("out_valid", 64'(out_valid), 64'(vis));
    chk("in_ready", 64'(in_ready), 64'(!vis || out_ready));
    if (reset || flush) begin
      q.delete();
    end else if (!vis || out_ready) begin
      if (vis) begin
        chk("out_data", out_data, q[0].d);
        chk("out_fflags", 64'(out_fflags), 64'(q[0].f));
        chk("out_tag", 64'(out_tag), 64'(q[0].t));
        fired    = 1;
        fire_d   = out_data;
        fire_f   = out_fflags;
        fire_cyc = cyc;
        fire_tags.push_back(out_tag);
        void'(q.pop_front());
      end
      foreach (q[i]) q[i].cnt++;
      if (in_valid) begin
        r = ref_op(in_op, in_dbl, in_a, in_b);
        q.push_back('{d: r[63:0], f: r[68:64], t: in_tag, cnt: 1});
        accepted = 1;
        acc_cyc  = cyc;
      end
    end
    cyc++;
  endtask

  task automatic step();
    #1;
    eval();
    @(negedge clk);
  endtask

  function automatic logic [63:0] gen(input logic dbl);
    logic [63:0] r;
    logic [31:0] s;
    int          k;
    r = {$urandom, $urandom};
    k = $urandom_range(0, 9);
    if (dbl) begin
      case (k)
        0: return 64'h0;
        1: return 64'h8000_0000_0000_0000;
        2: return {r[63], 11'h7FF, 52'h0};
        3: return {r[63], 11'h7FF, 1'b1, r[50:0]};
        4: return {r[63], 11'h7FF, 1'b0, r[50:1], 1'b1};
        5: return {r[63], 11'h000, r[51:0]};
        6, 7: return {r[63], 11'h3FE + 11'(r[1:0]), 52'h0};
        default: return r;
      endcase
    end
    case (k)
      0: s = 32'h0;
      1: s = 32'h8000_0000;
      2: s = {r[31], 8'hFF, 23'h0};
      3: s = {r[31], 8'hFF, 1'b1, r[21:0]};
      4: s = {r[31], 8'hFF, 1'b0, r[21:1], 1'b1};
      5: s = {r[31], 8'h00, r[22:0]};
      6, 7: s = {r[31], 8'h7E + 8'(r[1:0]), 23'h0};
      default: s = r[31:0];
    endcase
    if ($urandom_range(0, 7) == 0) return {1'b0, r[62:32], s};
    return {32'hFFFF_FFFF, s};
  endfunction

  task automatic idle(input int n);
    in_valid  = 0;
    flush     = 0;
    reset     = 0;
    out_ready = 1;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic dir_op(input string name, input logic [2:0] op, input logic dbl,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_d, input logic [4:0] exp_f);
    int lat;
    in_op = op; in_dbl = dbl; in_a = a; in_b = b; in_tag = 6'h2A;
    in_valid = 1; out_ready = 1; flush = 0;
    step();
    in_valid = 0;
    lat = 0;
    for (int k = 1; k <= int'(LAT) + 3; k++) begin
      step();
      if (fired && lat == 0) begin
        lat = k;
        chk({name, "_data"}, fire_d, exp_d);
        chk({name, "_flags"}, 64'(fire_f), 64'(exp_f));
      end
    end
    chk({name, "_latency"}, 64'(lat), 64'(LAT));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ns;
    reset = 1; flush = 0; in_valid = 0; out_ready = 1;
    in_op = 0; in_dbl = 0; in_a = 0; in_b = 0; in_tag = 0;
    repeat (3) @(negedge clk);
    reset = 0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_fflags", 64'(out_fflags), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    @(negedge clk);

    dir_op("dp_eq_zero", 3'd0, 1'b1, 64'h0, 64'h8000_0000_0000_0000, 64'd1, 5'b00000);
    dir_op("sp_lt_qnan", 3'd1, 1'b0, 64'hFFFF_FFFF_7FC0_0000, 64'hFFFF_FFFF_3F80_0000, 64'd0, 5'b10000);
    dir_op("dp_max_snan", 3'd4, 1'b1, 64'h7FF0_0000_0000_0001, 64'h3FF0_0000_0000_0000,
           64'h3FF0_0000_0000_0000, 5'b10000);
    dir_op("sp_min_unbox", 3'd3, 1'b0, 64'h0000_0000_3F80_0000, 64'hFFFF_FFFF_BF80_0000,
           64'hFFFF_FFFF_BF80_0000, 5'b00000);
    dir_op("dp_min_zero", 3'd3, 1'b1, 64'h0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'b0);
    dir_op("sp_class_sub", 3'd5, 1'b0, 64'hFFFF_FFFF_8000_0001, 64'h0, 64'h4, 5'b0);
    dir_op("undef_op", 3'd7, 1'b1, 64'h3FF0_0000_0000_0000, 64'h0, 64'h0, 5'b0);

    // backpressure: three back-to-back ops, output stalled for 5 cycles
    fire_tags.delete();
    ns = 0;
    in_dbl = 1; in_op = 3'd0; in_a = 64'h0; in_b = 64'h0;
    for (int c = 0; c < 40 && !(ns == 3 && q.size() == 0); c++) begin
      out_ready = (c >= 5);
      in_valid  = (ns < 3);
      in_tag    = TAG_W'(ns + 1);
      step();
      if (accepted) ns++;
    end
    in_valid = 0;
    chk("bp_count", 64'(fire_tags.size()), 64'd3);
    for (int i = 0; i < 3 && i < fire_tags.size(); i++)
      chk("bp_order", 64'(fire_tags[i]), 64'(i + 1));

    // flush with two ops in flight, then a fresh op right after
    idle(LAT + 2);
    fire_tags.delete();
    out_ready = 1;
    in_valid = 1; in_tag = 6'd10; step();
    in_tag = 6'd11; step();
    flush = 1; in_tag = 6'd12; step();
    flush = 0; in_tag = 6'd13; step();
    ns = acc_cyc;
    idle(LAT + 3);
    chk("flush_count", 64'(fire_tags.size()), 64'd1);
    if (fire_tags.size() > 0) chk("flush_survivor", 64'(fire_tags[0]), 64'd13);
    chk("flush_latency", 64'(fire_cyc - ns), 64'(LAT));

    // randomized traffic with stalls, flushes and one mid-run reset
    for (int n = 0; n < 2500; n++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 39) == 0);
      reset     = (n == 1200);
      in_dbl    = $urandom_range(0, 1) == 1;
      in_op     = ($urandom_range(0, 15) < 14) ? 3'($urandom_range(0, 5)) : 3'($urandom_range(6, 7));
      in_a      = gen(in_dbl);
      in_b      = ($urandom_range(0, 7) == 0) ? in_a : gen(in_dbl);
      in_tag    = TAG_W'($urandom);
      step();
      if (n == 1200) begin
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_data", out_data, 64'd0);
        chk("midrst_out_tag", 64'(out_tag), 64'd0);
      end
    end
    idle(LAT + 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
